wb_writer: RTL

//  Writeback-side producer for the integer register file write port (w_en/rd_index/rd_data).

---
 rtl/wb_writer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wb_writer.sv
// Writeback producer for the integer register file: merges buffered ALU results and formatted load responses.
// Optional register bypass ports are compiled in when WB_BYPASS_EN is defined.
module wb_writer #(
    parameter int XLEN       = 64,
    parameter int ALU_DEPTH  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [2:0]      ld_offset,
    input  logic [2:0]      ld_funct3,
`ifdef WB_BYPASS_EN
    input  logic [4:0]      byp_idx  [2],
    output logic            byp_hit  [2],
    output logic [XLEN-1:0] byp_data [2],
`endif
    output logic            w_en,
    output logic [4:0]      rd_index,
    output logic [XLEN-1:0] rd_data,
    output logic            pending
);

    localparam int AW = $clog2(ALU_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      mem_rd   [ALU_DEPTH];
    logic [XLEN-1:0] mem_data [ALU_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [SW-1:0]   starve;

    logic fifo_empty, fifo_full, push, grant_alu, grant_ld;
    logic [XLEN-1:0] sh, ld_fmt;
    logic            ld_legal;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(ALU_DEPTH));
    assign alu_ready  = !fifo_full;
    assign push       = alu_valid && alu_ready;

    // A waiting ALU entry yields to loads only until the FIFO fills or the starve limit is reached.
    assign grant_alu = !fifo_empty &&
                       (!ld_valid || fifo_full || (starve == SW'(STARVE_MAX)));
    assign grant_ld  = !grant_alu && ld_valid;
    assign ld_ready  = grant_ld;
    assign pending   = !fifo_empty || w_en;

    always_comb begin
        sh       = ld_data >> {ld_offset, 3'b000};
        ld_fmt   = '0;
        ld_legal = 1'b1;
        case (ld_funct3)
            3'b000:  ld_fmt = {{(XLEN-8){sh[7]}},   sh[7:0]};
            3'b001:  ld_fmt = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  ld_fmt = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b011:  ld_fmt = ld_data;
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}},    sh[7:0]};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}},   sh[15:0]};
            3'b110:  ld_fmt = {{(XLEN-32){1'b0}},   sh[31:0]};
            default: ld_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= alu_rd;
            mem_data[wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (grant_alu)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, grant_alu})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || grant_alu || fifo_empty)
            starve <= '0;
        else if (grant_ld && (starve != SW'(STARVE_MAX)))
            starve <= starve + 1'b1;
    end

    // rd==0 and illegal loads are still consumed, they just never assert the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en     <= 1'b0;
            rd_index <= '0;
            rd_data  <= '0;
        end else if (grant_alu) begin
            w_en     <= (mem_rd[rd_ptr] != 5'd0);
            rd_index <= mem_rd[rd_ptr];
            rd_data  <= mem_data[rd_ptr];
        end else if (grant_ld) begin
            w_en     <= (ld_rd != 5'd0) && ld_legal;
            rd_index <= ld_rd;
            rd_data  <= ld_fmt;
        end else begin
            w_en     <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    logic [AW-1:0] yng_ptr;
    assign yng_ptr = wr_ptr - 1'b1;

    // The youngest buffered result is newer than the output register, so it takes priority.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            byp_hit[i]  = 1'b0;
            byp_data[i] = '0;
            if (byp_idx[i] != 5'd0) begin
                if (!fifo_empty && (mem_rd[yng_ptr] == byp_idx[i])) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = mem_data[yng_ptr];
                end else if (w_en && (rd_index == byp_idx[i])) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = rd_data;
                end
            end
        end
    end
`endif

endmodule
